// File: rtl/pipeline_decode_hazard.sv
// Decode-side load-use hazard detector, early-branch flagger and ID/EX register.
// Optional macro DECODE_HAZARD_STATS_EN adds a cumulative stall_count output.
module pipeline_decode_hazard #(
  parameter int LOAD_LAT = 1,
  parameter int SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  input  logic        br_late_done_d1,
  output logic [1:0]  stall_request,
  output logic [3:0]  early_branch_cmd,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
`ifdef DECODE_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int IW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam logic [1:0] LAT = 2'(LOAD_LAT);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic           r_vld [SB_DEPTH];
  logic [4:0]     r_reg [SB_DEPTH];
  logic [1:0]     r_cnt [SB_DEPTH];
  logic [1:0]     r_hold;
  logic           r_first;

  logic [5:0]     w_op;
  logic [4:0]     w_rs;
  logic [4:0]     w_rt;
  logic           w_use_rs;
  logic           w_use_rt;
  logic           w_is_lw;
  logic           w_ign;
  logic           w_accept;
  logic           w_free_ok;
  logic [IW-1:0]  w_free_idx;
  logic [1:0]     w_n;
  logic [1:0]     w_stall;
  logic [3:0]     w_cmd;

  assign w_op = inst_in[31:26];
  assign w_rs = inst_in[25:21];
  assign w_rt = inst_in[20:16];

  assign w_use_rs = (w_op != OP_J) && (w_op != OP_JAL);
  assign w_use_rt = (w_op == OP_R) || (w_op == OP_SW) ||
                    (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_is_lw  = (w_op == OP_LW) && (w_rt != 5'd0);

  assign w_ign = rst || r_first || (r_hold != 2'd0) ||
                 br_late_done_d1 || (inst_in == 32'd0);

  // Worst-case remaining latency over all matching sources (pre-decrement)
  always_comb begin
    w_n = 2'd0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_vld[i] &&
          ((w_use_rs && (w_rs != 5'd0) && (r_reg[i] == w_rs)) ||
           (w_use_rt && (w_rt != 5'd0) && (r_reg[i] == w_rt))) &&
          (r_cnt[i] > w_n))
        w_n = r_cnt[i];
    end
  end

  // An entry expiring this cycle is reusable for this cycle's push
  always_comb begin
    w_free_ok  = 1'b0;
    w_free_idx = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i] || (r_cnt[i] == 2'd1)) begin
        w_free_ok  = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_stall = 2'd0;
    if (!w_ign) begin
      if (w_n != 2'd0)
        w_stall = w_n;
      else if (w_is_lw && !w_free_ok)
        w_stall = 2'd1;
    end
  end

  assign w_accept = !w_ign && (w_stall == 2'd0);

  always_comb begin
    w_cmd = 4'd0;
    if (w_accept) begin
      unique case (1'b1)
        (w_op == OP_J):   w_cmd = 4'd1;
        (w_op == OP_JAL): w_cmd = 4'd2;
        (w_op == OP_BEQ) && (w_rs == 5'd0) && (w_rt == 5'd0):
                          w_cmd = 4'd3;
        default:          w_cmd = 4'd0;
      endcase
    end
  end

  assign stall_request    = w_stall;
  assign early_branch_cmd = w_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_reg[i] <= 5'd0;
        r_cnt[i] <= 2'd0;
      end
      r_hold   <= 2'd0;
      r_first  <= 1'b1;
      inst_out <= 32'd0;
      pc_out   <= 32'd0;
    end else begin
      r_first <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (r_vld[i]) begin
          r_cnt[i] <= r_cnt[i] - 2'd1;
          if (r_cnt[i] == 2'd1)
            r_vld[i] <= 1'b0;
        end
      end
      if (w_accept && w_is_lw) begin
        r_vld[w_free_idx] <= 1'b1;
        r_reg[w_free_idx] <= w_rt;
        r_cnt[w_free_idx] <= LAT;
      end
      if (w_stall != 2'd0)
        r_hold <= w_stall - 2'd1;
      else if (r_hold != 2'd0)
        r_hold <= r_hold - 2'd1;
      inst_out <= w_accept ? inst_in : 32'd0;
      if (w_accept)
        pc_out <= pc_in;
    end
  end

`ifdef DECODE_HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= 32'd0;
    else
      stall_count <= stall_count + 32'(w_stall);
  end
`endif

endmodule
